// File: rtl/rtype_exec_ctrl_if.sv
// Fetch/regfile-facing bus of the R-type execute controller: instruction handshake,
// regfile read addresses/data and the single write-back port.
interface rtype_exec_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [4:0]        readReg1;
    logic [4:0]        readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              write;
    logic [4:0]        writeReg;
    logic [DATA_W-1:0] writeData;
    logic              done;
    logic              illegal;

    // master: fetch + regfile side
    modport master (
        output instr_valid, instr, readData1, readData2,
        input  instr_ready, readReg1, readReg2, write, writeReg, writeData, done, illegal
    );

    modport slave (
        input  instr_valid, instr, readData1, readData2,
        output instr_ready, readReg1, readReg2, write, writeReg, writeData, done, illegal
    );
endinterface

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle execute/write-back controller for MIPS R-type instructions.
// Latency: write-back 2 edges after accept for ALU ops, DATA_W+2 edges for MUL.
// Backpressure: instr_ready only in IDLE; one instruction in flight, never overlapped.
module rtype_exec_ctrl #(
    parameter int DATA_W = 32,
    parameter int MUL_EN = 1
) (
    input  logic               clk,
    input  logic               resetn,
    rtype_exec_ctrl_if.slave   bus
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    state_t            state, state_nxt;
    instr_t            ir;
    logic              ill_q;
    logic [DATA_W-1:0] acc, mcand, mplier, acc_nxt;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] alu_res;
    logic              is_mul, is_legal, mul_last, rd_nz;
    logic [DATA_W-1:0] write_data_q;
    logic [4:0]        write_reg_q;

    // Decode and ALU, evaluated in EXEC while readData is valid
    always_comb begin
        alu_res  = '0;
        is_legal = (ir.op == 6'd0);
        is_mul   = (MUL_EN != 0) && (ir.funct == 6'h18);
        case (ir.funct)
            6'h20: alu_res = bus.readData1 + bus.readData2;
            6'h22: alu_res = bus.readData1 - bus.readData2;
            6'h24: alu_res = bus.readData1 & bus.readData2;
            6'h25: alu_res = bus.readData1 | bus.readData2;
            6'h26: alu_res = bus.readData1 ^ bus.readData2;
            6'h27: alu_res = ~(bus.readData1 | bus.readData2);
            6'h2A: alu_res = {{(DATA_W-1){1'b0}},
                              ($signed(bus.readData1) < $signed(bus.readData2))};
            6'h00: alu_res = bus.readData2 << ir.shamt;
            6'h02: alu_res = bus.readData2 >> ir.shamt;
            6'h03: alu_res = $signed(bus.readData2) >>> ir.shamt;
            6'h18: begin
                if (!is_mul) is_legal = 1'b0;
            end
            default: is_legal = 1'b0;
        endcase
    end

    assign mul_last = (cnt == CW'(DATA_W-1));
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    assign rd_nz    = (ir.rd != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.instr_valid) state_nxt = READ;
            READ: state_nxt = EXEC;
            EXEC: state_nxt = (is_legal && is_mul) ? MUL : WB;
            MUL:  if (mul_last) state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = (state == IDLE);
        bus.done        = (state == WB);
        bus.illegal     = (state == WB) && ill_q;
        bus.write       = (state == WB) && !ill_q && rd_nz;
    end

    assign bus.readReg1  = ir.rs;
    assign bus.readReg2  = ir.rt;
    assign bus.writeReg  = write_reg_q;
    assign bus.writeData = write_data_q;

    // writeReg/writeData only load when a write will really issue, so they hold otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ir           <= '0;
            ill_q        <= 1'b0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        ir    <= bus.instr;
                        ill_q <= 1'b0;
                    end
                end
                EXEC: begin
                    ill_q <= !is_legal;
                    if (is_legal && is_mul) begin
                        acc    <= '0;
                        mcand  <= bus.readData1;
                        mplier <= bus.readData2;
                        cnt    <= '0;
                    end else if (is_legal && rd_nz) begin
                        write_data_q <= alu_res;
                        write_reg_q  <= ir.rd;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (mul_last && rd_nz) begin
                        write_data_q <= acc_nxt;
                        write_reg_q  <= ir.rd;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
